dm_cache_ctrl: RTL and testbench

DM_CACHE_CTRL -- requirements
Module: dm_cache_ctrl

---
 rtl/dm_cache_ctrl.sv | 99 +++++++++
 tb/tb_dm_cache_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped cache tag controller with refill handshake and saturating hit/miss counters.
// The tag/valid read is registered, so LOOKUP spends one cycle reading and one cycle deciding.
module dm_cache_ctrl #(
  parameter int INDEX_BITS  = 8,
  parameter int OFFSET_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  output logic        resp_hit,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int TAG_W = 32 - INDEX_BITS - OFFSET_BITS;
  localparam int LINES = 1 << INDEX_BITS;
  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, MEM_WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, hit_count_q, hit_count_d, miss_count_q, miss_count_d;
  logic lk_q, lk_d, hit_q, hit_d, resp_hit_q, resp_hit_d, fill;
  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0] tag_l;
  assign idx   = addr_q[OFFSET_BITS +: INDEX_BITS];
  assign tag_l = addr_q[31 -: TAG_W];
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    lk_d         = 1'b0;
    hit_d        = hit_q;
    resp_hit_d   = 1'b0;
    valid_d      = valid_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    fill         = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d  = req_addr;
        state_d = LOOKUP;
      end
      LOOKUP: if (!lk_q) begin
        lk_d  = 1'b1;
        hit_d = valid_q[idx] && (tag_q[idx] == tag_l);
      end else if (hit_q) begin
        state_d     = RESP;
        resp_hit_d  = 1'b1;
        hit_count_d = hit_count_q + {31'b0, hit_count_q != '1};
      end else begin
        state_d      = MEM_REQ;
        miss_count_d = miss_count_q + {31'b0, miss_count_q != '1};
      end
      MEM_REQ: state_d = mem_req_ready ? MEM_WAIT : MEM_REQ;
      MEM_WAIT: if (mem_resp_valid) begin
        fill         = 1'b1;
        valid_d[idx] = 1'b1;
        state_d      = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      lk_q         <= 1'b0;
      hit_q        <= 1'b0;
      resp_hit_q   <= 1'b0;
      valid_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      lk_q         <= lk_d;
      hit_q        <= hit_d;
      resp_hit_q   <= resp_hit_d;
      valid_q      <= valid_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && fill) tag_q[idx] <= tag_l;
  end
  assign req_ready     = state_q == IDLE;
  assign resp_valid    = state_q == RESP;
  assign resp_hit      = resp_hit_q;
  assign mem_req_valid = state_q == MEM_REQ;
  assign mem_req_addr  = {addr_q[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign hit_count     = hit_count_q;
  assign miss_count    = miss_count_q;
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: directed checks of dm_cache_ctrl with immediate assertions.
module tb_dm_cache_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic req_ready, resp_valid, resp_hit, mem_req_valid;
  logic [31:0] mem_req_addr, hit_count, miss_count;
  int n_cmp = 0, n_bad = 0;

  dm_cache_ctrl #(.INDEX_BITS(8), .OFFSET_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic accept(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic refill();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_mem_req_addr", mem_req_addr, 32'h0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);

    accept(32'h0000_1000);
    chk("cold_req_ready_busy", {31'b0, req_ready}, 32'd0);
    tick();
    tick();
    chk("cold_mem_req_valid", {31'b0, mem_req_valid}, 32'd1);
    chk("cold_mem_req_addr", mem_req_addr, 32'h0000_1000);
    chk("cold_misses", miss_count, 32'd1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("cold_wait_no_req", {31'b0, mem_req_valid}, 32'd0);
    chk("cold_wait_no_resp", {31'b0, resp_valid}, 32'd0);
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    chk("cold_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("cold_resp_hit", {31'b0, resp_hit}, 32'd0);
    tick();
    chk("cold_back_idle", {31'b0, req_ready}, 32'd1);
    chk("cold_resp_pulse", {31'b0, resp_valid}, 32'd0);

    accept(32'h0000_100C);
    tick();
    chk("hit_not_early", {31'b0, resp_valid}, 32'd0);
    tick();
    chk("hit_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("hit_resp_hit", {31'b0, resp_hit}, 32'd1);
    chk("hit_hits", hit_count, 32'd1);
    chk("hit_misses", miss_count, 32'd1);
    tick();

    accept(32'h0000_2000);
    tick();
    tick();
    chk("evict_miss", {31'b0, mem_req_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_mem_req_valid", {31'b0, mem_req_valid}, 32'd1);
      chk("bp_mem_req_addr", mem_req_addr, 32'h0000_2000);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    refill();
    chk("evict_resp_hit", {31'b0, resp_hit & resp_valid}, 32'd0);
    tick();
    accept(32'h0000_1000);
    tick();
    tick();
    chk("evict_again_miss", {31'b0, mem_req_valid}, 32'd1);
    refill();
    chk("evict_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("evict_resp_hit2", {31'b0, resp_hit}, 32'd0);
    chk("evict_misses", miss_count, 32'd3);
    chk("evict_hits", hit_count, 32'd1);
    tick();

    accept(32'h0000_3000);
    tick();
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    do_reset();
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("midrst_hits", hit_count, 32'd0);
    chk("midrst_misses", miss_count, 32'd0);
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    chk("late_pulse_no_resp", {31'b0, resp_valid}, 32'd0);
    chk("late_pulse_idle", {31'b0, req_ready}, 32'd1);
    accept(32'h0000_1000);
    tick();
    tick();
    chk("postrst_miss", {31'b0, mem_req_valid}, 32'd1);
    chk("postrst_misses", miss_count, 32'd1);
    refill();
    tick();

    do_reset();
    req_valid = 1'b1;
    req_addr  = 32'h0;
    tick();
    tick();
    tick();
    chk("b2b_busy", {31'b0, req_ready}, 32'd0);
    refill();
    chk("b2b_first_resp", {31'b0, resp_valid}, 32'd1);
    chk("b2b_resp_not_ready", {31'b0, req_ready}, 32'd0);
    req_addr = 32'h4;
    tick();
    chk("b2b_idle_after_resp", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("b2b_second_accepted", {31'b0, req_ready}, 32'd0);
    tick();
    tick();
    chk("b2b_second_resp", {31'b0, resp_valid}, 32'd1);
    chk("b2b_second_hit", {31'b0, resp_hit}, 32'd1);
    chk("b2b_hits", hit_count, 32'd1);
    chk("b2b_misses", miss_count, 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
